// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester/arbiter bundle for the shared shift-add multiplier
//
// Signals:
//   req0/req1         requester asks for one multiply, held until its done pulse
//   mcd0/mlt0         requester 0 multiplicand / multiplier
//   mcd1/mlt1         requester 1 multiplicand / multiplier
//   gnt0/gnt1         requester owns the multiplier (RUN and DONE)
//   busy              multiplier is running or finishing
//   prod              product of the last completed operation
//   done0/done1       one-cycle pulse, prod valid for that requester
// Modports:
//   master            requester side (drives req/operands)
//   slave             arbiter side (drives grants, status and product)
interface mult_arbiter_if #(
  parameter int WIDTH = 8
);
  logic               req0;
  logic [WIDTH-1:0]   mcd0;
  logic [WIDTH-1:0]   mlt0;
  logic               req1;
  logic [WIDTH-1:0]   mcd1;
  logic [WIDTH-1:0]   mlt1;
  logic               gnt0;
  logic               gnt1;
  logic               busy;
  logic [2*WIDTH-1:0] prod;
  logic               done0;
  logic               done1;

  modport master (
    output req0, mcd0, mlt0, req1, mcd1, mlt1,
    input  gnt0, gnt1, busy, prod, done0, done1
  );

  modport slave (
    input  req0, mcd0, mlt0, req1, mcd1, mlt1,
    output gnt0, gnt1, busy, prod, done0, done1
  );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester round-robin arbiter around one shift-add multiplier
//
// Ports:
//   clk     single clock, all state changes on the rising edge
//   rst_n   asynchronous active-low reset
//   bus     mult_arbiter_if.slave: req/operands in, gnt/busy/prod/done out
// Operation:
//   IDLE picks a winner (round-robin on contention) and samples its operands,
//   RUN performs WIDTH shift-add steps, DONE presents the product for one cycle
//   and hands round-robin priority to the other requester.
module mult_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_arbiter_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mreg;
  logic [CW-1:0]      cnt;
  logic               owner;
  logic               rr;
  logic [2*WIDTH-1:0] prod;

  logic               any_req;
  logic               win;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   acc_step;

  logic               gnt0;
  logic               gnt1;
  logic               busy;
  logic               done0;
  logic               done1;

  assign any_req = bus.req0 | bus.req1;
  // On contention the round-robin pointer decides; otherwise the lone requester wins.
  assign win = (bus.req0 & bus.req1) ? rr : bus.req1;

  // One shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right. acc[2*WIDTH] is always zero here,
  // so the 9-bit sum keeps the carry that the shift moves down into bit 2*WIDTH-1.
  always_comb begin
    sum = acc[2*WIDTH:WIDTH];
    if (acc[0]) begin
      sum = acc[2*WIDTH:WIDTH] + {1'b0, mreg};
    end
    acc_step = {1'b0, sum, acc[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (any_req) state_n = RUN;
      RUN:  if (cnt == LAST) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the state so reset clears them immediately.
  always_comb begin
    busy  = (state == RUN) || (state == DONE);
    gnt0  = busy & ~owner;
    gnt1  = busy & owner;
    done0 = (state == DONE) & ~owner;
    done1 = (state == DONE) & owner;
  end

  // Datapath, owner and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mreg  <= '0;
      cnt   <= '0;
      owner <= 1'b0;
      rr    <= 1'b0;
      prod  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= win;
            mreg  <= win ? bus.mcd1 : bus.mcd0;
            acc   <= {{(WIDTH+1){1'b0}}, (win ? bus.mlt1 : bus.mlt0)};
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          // The last step's result goes straight to prod as DONE is entered.
          if (cnt == LAST) begin
            prod <= acc_step[2*WIDTH-1:0];
          end
        end
        DONE: begin
          rr <= ~owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign bus.busy  = busy;
  assign bus.done0 = done0;
  assign bus.done1 = done1;
  assign bus.prod  = prod;

endmodule
